// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU slice.
//   - WIDTH_DEF : default operand/result width
//   - ALU_*     : 4-bit ALU control codes understood by the shared ALU
package alu_pkg;

  localparam int WIDTH_DEF = 64;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU shared by the arbiter.
// Ports:
//   BusA, BusB : operands (WIDTH bits)
//   ALUCtrl    : 4-bit operation code (see alu_pkg)
//   BusW       : result, modulo 2^WIDTH; unknown codes give 0
//   Zero       : high when BusW is zero
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [3:0]       ALUCtrl,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero
);

  always_comb begin
    BusW = '0;
    case (ALUCtrl)
      ALU_AND:   BusW = BusA & BusB;
      ALU_OR:    BusW = BusA | BusB;
      ALU_ADD:   BusW = BusA + BusB;
      ALU_SUB:   BusW = BusA - BusB;
      ALU_PASSB: BusW = BusB;
      default:   BusW = '0;
    endcase
  end

  assign Zero = (BusW == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// The granted request drives the ALU combinationally; its result, Zero flag
// and requester id are captured in a single output register with its own
// valid/ready handshake.
// Ports:
//   CLK, Reset                  : clock, asynchronous active-high reset
//   ReqValid0/1, ReqReady0/1    : request handshakes
//   ReqA0/1, ReqB0/1, ReqCtrl0/1: operands and ALU control per requester
//   RspValid, RspReady          : output register handshake
//   RspW, RspZero, RspId        : registered result, zero flag, requester id
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             ReqValid0,
  input  logic             ReqValid1,
  output logic             ReqReady0,
  output logic             ReqReady1,
  input  logic [WIDTH-1:0] ReqA0,
  input  logic [WIDTH-1:0] ReqA1,
  input  logic [WIDTH-1:0] ReqB0,
  input  logic [WIDTH-1:0] ReqB1,
  input  logic [3:0]       ReqCtrl0,
  input  logic [3:0]       ReqCtrl1,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [WIDTH-1:0] RspW,
  output logic             RspZero,
  output logic             RspId
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_w_q, rsp_w_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_id_q, rsp_id_d;
  logic             last_q, last_d;

  logic             grant_vld;
  logic             grant_id;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] alu_a, alu_b, alu_w;
  logic [3:0]       alu_ctrl;
  logic             alu_zero;

  // Grant depends only on the valids and the pointer, never on payload,
  // so there is no path from operands/control to the handshake outputs.
  always_comb begin
    grant_vld = ReqValid0 | ReqValid1;
    grant_id  = 1'b0;
    if (ReqValid0 && ReqValid1) begin
      grant_id = ~last_q;
    end else if (ReqValid1) begin
      grant_id = 1'b1;
    end
  end

  assign can_accept = !rsp_valid_q || RspReady;

  // Gating with Reset keeps both readies low while reset is held, since the
  // register contents alone would otherwise report an empty output stage.
  assign ReqReady0 = !Reset && can_accept && grant_vld && !grant_id;
  assign ReqReady1 = !Reset && can_accept && grant_vld &&  grant_id;
  assign xfer      = ReqReady0 | ReqReady1;

  assign alu_a    = grant_id ? ReqA1    : ReqA0;
  assign alu_b    = grant_id ? ReqB1    : ReqB0;
  assign alu_ctrl = grant_id ? ReqCtrl1 : ReqCtrl0;

  alu_arbiter_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .BusA   (alu_a),
    .BusB   (alu_b),
    .ALUCtrl(alu_ctrl),
    .BusW   (alu_w),
    .Zero   (alu_zero)
  );

  // A push takes priority over a pop, which covers the simultaneous
  // pop-and-push case: the new result replaces the old and valid stays set.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_w_d     = rsp_w_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_id_d    = rsp_id_q;
    last_d      = last_q;
    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_w_d     = alu_w;
      rsp_zero_d  = alu_zero;
      rsp_id_d    = grant_id;
      last_d      = grant_id;
    end else if (rsp_valid_q && RspReady) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Output register and round-robin pointer; `last` resets to 1 so that
  // requester 0 wins the first contended cycle.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rsp_valid_q <= 1'b0;
      rsp_w_q     <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_id_q    <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_w_q     <= rsp_w_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_id_q    <= rsp_id_d;
      last_q      <= last_d;
    end
  end

  assign RspValid = rsp_valid_q;
  assign RspW     = rsp_w_q;
  assign RspZero  = rsp_zero_q;
  assign RspId    = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        ReqValid0 = 1'b0, ReqValid1 = 1'b0;
  logic        ReqReady0, ReqReady1;
  logic [63:0] ReqA0 = '0, ReqA1 = '0, ReqB0 = '0, ReqB1 = '0;
  logic [3:0]  ReqCtrl0 = '0, ReqCtrl1 = '0;
  logic        RspValid;
  logic        RspReady = 1'b0;
  logic [63:0] RspW;
  logic        RspZero;
  logic        RspId;

  int checks = 0;
  int passes = 0;

  // Reference model state
  bit          m_valid;
  logic [63:0] m_w;
  bit          m_zero;
  bit          m_id;
  bit          m_last;

  alu_arbiter #(.WIDTH(64)) dut (
    .CLK(CLK), .Reset(Reset),
    .ReqValid0(ReqValid0), .ReqValid1(ReqValid1),
    .ReqReady0(ReqReady0), .ReqReady1(ReqReady1),
    .ReqA0(ReqA0), .ReqA1(ReqA1), .ReqB0(ReqB0), .ReqB1(ReqB1),
    .ReqCtrl0(ReqCtrl0), .ReqCtrl1(ReqCtrl1),
    .RspValid(RspValid), .RspReady(RspReady),
    .RspW(RspW), .RspZero(RspZero), .RspId(RspId)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] model_alu(logic [63:0] a, logic [63:0] b, logic [3:0] c);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return b;
      default: return 64'd0;
    endcase
  endfunction

  // Requester n is accepted when the output stage can take a result, n is
  // asking, and either n asks alone or n was not the last one served.
  function automatic bit exp_rdy(int n);
    bit can, mine, other;
    can   = !m_valid || RspReady;
    mine  = (n == 0) ? ReqValid0 : ReqValid1;
    other = (n == 0) ? ReqValid1 : ReqValid0;
    return can && mine && (!other || (m_last != n[0]));
  endfunction

  task automatic model_reset();
    m_valid = 0; m_w = '0; m_zero = 0; m_id = 0; m_last = 1;
  endtask

  // Advance one clock edge, updating the model from the inputs seen before it.
  task automatic cycle();
    bit r0, r1;
    logic [63:0] res;
    r0 = exp_rdy(0);
    r1 = exp_rdy(1);
    @(posedge CLK);
    if (r0 || r1) begin
      res = r0 ? model_alu(ReqA0, ReqB0, ReqCtrl0) : model_alu(ReqA1, ReqB1, ReqCtrl1);
      m_valid = 1; m_w = res; m_zero = (res == 0); m_id = r1; m_last = r1;
    end else if (m_valid && RspReady) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    ReqValid0 = 0; ReqValid1 = 0; RspReady = 1;
  endtask

  task automatic test_reset();
    Reset = 1; ReqValid0 = 1; ReqValid1 = 1; RspReady = 1;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (ReqReady0 !== 1'b0) $display("FAIL rst_ready0 got %b want 0", ReqReady0); else passes++;
    checks++; if (ReqReady1 !== 1'b0) $display("FAIL rst_ready1 got %b want 0", ReqReady1); else passes++;
    checks++; if (RspValid !== 1'b0) $display("FAIL rst_valid got %b want 0", RspValid); else passes++;
    checks++; if (RspW !== 64'd0) $display("FAIL rst_w got %h want 0", RspW); else passes++;
    checks++; if (RspZero !== 1'b0 || RspId !== 1'b0)
      $display("FAIL rst_zero_id got %b%b want 00", RspZero, RspId); else passes++;
    Reset = 0;
    model_reset();
    idle_inputs();
    #1;
  endtask

  task automatic test_single_req0();
    ReqValid0 = 1; ReqA0 = 64'd5; ReqB0 = 64'd3; ReqCtrl0 = 4'b0010; RspReady = 1;
    #1;
    checks++; if (ReqReady0 !== 1'b1) $display("FAIL single_ready0 got %b want 1", ReqReady0); else passes++;
    cycle();
    ReqValid0 = 0;
    checks++; if (RspValid !== 1'b1 || RspW !== 64'd8 || RspZero !== 1'b0 || RspId !== 1'b0)
      $display("FAIL single_rsp got v=%b w=%0d z=%b id=%b want v=1 w=8 z=0 id=0",
                RspValid, RspW, RspZero, RspId); else passes++;
  endtask

  task automatic test_req1_ops();
    ReqValid1 = 1; ReqA1 = 64'd7; ReqB1 = 64'd7; ReqCtrl1 = 4'b0110; RspReady = 1;
    #1;
    checks++; if (ReqReady1 !== 1'b1) $display("FAIL req1_ready got %b want 1", ReqReady1); else passes++;
    cycle();
    checks++; if (RspW !== 64'd0 || RspZero !== 1'b1 || RspId !== 1'b1)
      $display("FAIL req1_sub got w=%0d z=%b id=%b want w=0 z=1 id=1", RspW, RspZero, RspId); else passes++;
    ReqA1 = 64'd1; ReqB1 = 64'd2; ReqCtrl1 = 4'b1111;
    cycle();
    ReqValid1 = 0;
    checks++; if (RspValid !== 1'b1 || RspW !== 64'd0 || RspZero !== 1'b1)
      $display("FAIL req1_badctrl got v=%b w=%0d z=%b want v=1 w=0 z=1", RspValid, RspW, RspZero); else passes++;
  endtask

  task automatic test_fairness();
    int exp_ids[6] = '{0, 1, 0, 1, 0, 1};
    Reset = 1; #2; Reset = 0; model_reset();
    ReqValid0 = 1; ReqValid1 = 1; RspReady = 1;
    for (int i = 0; i < 6; i++) begin
      ReqA0 = 64'($urandom); ReqB0 = 64'($urandom); ReqCtrl0 = 4'b0010;
      ReqA1 = 64'($urandom); ReqB1 = 64'($urandom); ReqCtrl1 = 4'b0110;
      #1;
      cycle();
      checks++; if (RspValid !== 1'b1 || RspId !== exp_ids[i][0] || RspW !== m_w)
        $display("FAIL fair_%0d got v=%b id=%b w=%h want v=1 id=%0d w=%h",
                 i, RspValid, RspId, RspW, exp_ids[i], m_w); else passes++;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    held = m_w;
    RspReady = 0;
    ReqValid0 = 1; ReqValid1 = 1;
    ReqA0 = 64'd100; ReqB0 = 64'd23; ReqCtrl0 = 4'b0010;
    ReqA1 = 64'hF0; ReqB1 = 64'h3C; ReqCtrl1 = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ReqReady0 !== 1'b0 || ReqReady1 !== 1'b0)
        $display("FAIL bp_ready_%0d got %b%b want 00", i, ReqReady0, ReqReady1); else passes++;
      cycle();
      checks++; if (RspValid !== 1'b1 || RspW !== held)
        $display("FAIL bp_hold_%0d got v=%b w=%h want v=1 w=%h", i, RspValid, RspW, held); else passes++;
    end
    RspReady = 1;
    #1;
    checks++; if (ReqReady0 !== exp_rdy(0) || ReqReady1 !== exp_rdy(1))
      $display("FAIL bp_release_ready got %b%b want %b%b", ReqReady0, ReqReady1, exp_rdy(0), exp_rdy(1)); else passes++;
    cycle();
    checks++; if (RspValid !== 1'b1 || RspW !== m_w || RspId !== m_id)
      $display("FAIL bp_poppush got v=%b w=%h id=%b want v=1 w=%h id=%b", RspValid, RspW, RspId, m_w, m_id); else passes++;
  endtask

  task automatic test_reset_mid();
    checks++; if (RspValid !== 1'b1) $display("FAIL mid_pre_valid got %b want 1", RspValid); else passes++;
    Reset = 1;
    #1;
    checks++; if (RspValid !== 1'b0 || RspW !== 64'd0 || RspId !== 1'b0)
      $display("FAIL mid_reset got v=%b w=%h id=%b want v=0 w=0 id=0", RspValid, RspW, RspId); else passes++;
    model_reset();
    @(posedge CLK); #1;
    checks++; if (RspValid !== 1'b0) $display("FAIL mid_hold_valid got %b want 0", RspValid); else passes++;
    Reset = 0;
    ReqValid0 = 1; ReqValid1 = 1; RspReady = 1;
    ReqA0 = 64'd9; ReqB0 = 64'd4; ReqCtrl0 = 4'b0001;
    #1;
    checks++; if (ReqReady0 !== 1'b1 || ReqReady1 !== 1'b0)
      $display("FAIL mid_grant got %b%b want 10", ReqReady0, ReqReady1); else passes++;
    cycle();
    checks++; if (RspId !== 1'b0 || RspW !== 64'd13)
      $display("FAIL mid_rsp got id=%b w=%0d want id=0 w=13", RspId, RspW); else passes++;
    idle_inputs();
    cycle();
  endtask

  task automatic test_boundary();
    ReqValid0 = 1; RspReady = 1;
    ReqA0 = 64'hFFFF_FFFF_FFFF_FFFF; ReqB0 = 64'h10; ReqCtrl0 = 4'b0111;
    #1;
    cycle();
    checks++; if (RspW !== 64'h10 || RspZero !== 1'b0)
      $display("FAIL passb got w=%h z=%b want w=10 z=0", RspW, RspZero); else passes++;
    ReqB0 = 64'd1; ReqCtrl0 = 4'b0010;
    cycle();
    checks++; if (RspW !== 64'd0 || RspZero !== 1'b1)
      $display("FAIL add_wrap got w=%h z=%b want w=0 z=1", RspW, RspZero); else passes++;
    idle_inputs();
    cycle();
  endtask

  task automatic test_random();
    logic [3:0] codes[8] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd2, 4'd6, 4'd15};
    for (int i = 0; i < 200; i++) begin
      ReqValid0 = 1'($urandom); ReqValid1 = 1'($urandom);
      RspReady  = ($urandom_range(0, 3) != 0);
      ReqA0 = {32'($urandom), 32'($urandom)}; ReqB0 = {32'($urandom), 32'($urandom)};
      ReqA1 = {32'($urandom), 32'($urandom)}; ReqB1 = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 7) == 0) ReqB1 = ReqA1;
      ReqCtrl0 = codes[$urandom_range(0, 7)];
      ReqCtrl1 = codes[$urandom_range(0, 7)];
      #1;
      checks++; if (ReqReady0 !== exp_rdy(0) || ReqReady1 !== exp_rdy(1))
        $display("FAIL rand_ready_%0d got %b%b want %b%b", i, ReqReady0, ReqReady1, exp_rdy(0), exp_rdy(1)); else passes++;
      cycle();
      checks++; if (RspValid !== m_valid || RspW !== m_w || RspZero !== m_zero || RspId !== m_id)
        $display("FAIL rand_rsp_%0d got v=%b w=%h z=%b id=%b want v=%b w=%h z=%b id=%b",
                 i, RspValid, RspW, RspZero, RspId, m_valid, m_w, m_zero, m_id); else passes++;
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_req0();
    test_req1_ops();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
